// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: state encoding, instruction and PC
// defaults, and the sequential PC step.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0800;
  localparam logic [15:0] RESET_PC_DEFAULT  = 16'h0000;
  localparam logic [15:0] PC_INC            = 16'd2;

  // 16-bit wrapping increment: 16'hFFFE steps to 16'h0000.
  function automatic logic [15:0] pc_step(input logic [15:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register with load enable and synchronous reset.
module pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] d,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= RESET_PC;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues instruction-memory reads at PC and holds one
// fetched instruction for decode, with redirect, stall, halt and error handling.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] PC_In,
  input  logic        PC_Sel,
  input  logic        nHaltSig,
  input  logic        Stall,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [15:0] PC_Next,
  output logic        err
);

  fetch_state_e state_q, state_n;
  logic [15:0]  pc_q, pc_d;
  logic         pc_load;
  logic [15:0]  instr_q, instr_n;
  logic [15:0]  pc_next_q, pc_next_n;
  logic         valid_q, valid_n;
  logic         err_q, err_n;
  logic         pend_q, pend_n;
  logic [15:0]  redir_q, redir_n;

  logic halt_now;
  logic bad_redirect;
  logic can_issue;
  logic consume;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .load(pc_load),
    .d   (pc_d),
    .q   (pc_q)
  );

  assign halt_now     = valid_q && !nHaltSig;
  assign bad_redirect = PC_Sel && PC_In[0];
  assign can_issue    = !valid_q || !Stall;
  assign consume      = valid_q && !Stall;

  // An outstanding read keeps imem_rd/imem_addr stable until imem_done;
  // halt and odd redirects drop the request in the cycle they are seen.
  always_comb begin
    imem_rd = 1'b0;
    if (!rst && !halt_now && !bad_redirect) begin
      case (state_q)
        ST_FETCH: imem_rd = can_issue;
        ST_WAIT:  imem_rd = 1'b1;
        default:  imem_rd = 1'b0;
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign PC_Next     = pc_next_q;
  assign err         = err_q;

  always_comb begin
    state_n   = state_q;
    instr_n   = instr_q;
    pc_next_n = pc_next_q;
    valid_n   = valid_q;
    err_n     = err_q;
    pend_n    = pend_q;
    redir_n   = redir_q;
    pc_d      = pc_q;
    pc_load   = 1'b0;

    if (state_q == ST_HALTED) begin
      valid_n = 1'b0;
      instr_n = NOP_INSTR;
    end else if (halt_now) begin
      // Halt outranks any redirect arriving in the same cycle.
      state_n = ST_HALTED;
      valid_n = 1'b0;
      instr_n = NOP_INSTR;
      pend_n  = 1'b0;
    end else if (bad_redirect) begin
      state_n = ST_HALTED;
      err_n   = 1'b1;
      valid_n = 1'b0;
      instr_n = NOP_INSTR;
      pend_n  = 1'b0;
    end else begin
      if (consume) begin
        valid_n = 1'b0;
        instr_n = NOP_INSTR;
      end

      if (imem_rd && imem_done) begin
        state_n = ST_FETCH;
        if (PC_Sel || pend_q) begin
          // Word fetched down the wrong path: drop it and jump.
          pc_d    = PC_Sel ? PC_In : redir_q;
          pc_load = 1'b1;
          pend_n  = 1'b0;
          valid_n = 1'b0;
          instr_n = NOP_INSTR;
        end else begin
          instr_n   = imem_data;
          pc_next_n = pc_step(pc_q);
          valid_n   = 1'b1;
          pc_d      = pc_step(pc_q);
          pc_load   = 1'b1;
        end
      end else if (imem_rd) begin
        state_n = ST_WAIT;
        if (PC_Sel) begin
          pend_n  = 1'b1;
          redir_n = PC_In;
        end
      end else if (PC_Sel) begin
        pc_d    = PC_In;
        pc_load = 1'b1;
        valid_n = 1'b0;
        instr_n = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      instr_q   <= NOP_INSTR;
      pc_next_q <= pc_step(RESET_PC);
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
      redir_q   <= RESET_PC;
    end else begin
      state_q   <= state_n;
      instr_q   <= instr_n;
      pc_next_q <= pc_next_n;
      valid_q   <= valid_n;
      err_q     <= err_n;
      pend_q    <= pend_n;
      redir_q   <= redir_n;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a combinational instruction memory.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] PC_In;
  logic        PC_Sel;
  logic        nHaltSig;
  logic        Stall;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_done;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] PC_Next;
  logic        err;

  logic zero_wait;
  logic done_manual;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (16'h0000),
    .NOP_INSTR(16'h0800)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .PC_In      (PC_In),
    .PC_Sel     (PC_Sel),
    .nHaltSig   (nHaltSig),
    .Stall      (Stall),
    .imem_rd    (imem_rd),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .imem_done  (imem_done),
    .instr      (instr),
    .instr_valid(instr_valid),
    .PC_Next    (PC_Next),
    .err        (err)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h4001;
      16'h0002: return 16'h4802;
      default:  return a ^ 16'hA500;
    endcase
  endfunction

  assign imem_data = mem_word(imem_addr);
  assign imem_done = zero_wait ? imem_rd : done_manual;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic zw);
    rst = 1'b1; PC_Sel = 1'b0; PC_In = '0; nHaltSig = 1'b1; Stall = 1'b0;
    done_manual = 1'b0; zero_wait = zw;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; PC_Sel = 1'b0; PC_In = '0; nHaltSig = 1'b1; Stall = 1'b0;
    done_manual = 1'b0; zero_wait = 1'b1;

    // Reset values, and no request while rst is held.
    tick();
    check("rst_rd",    16'(imem_rd), 16'h0000);
    check("rst_valid", 16'(instr_valid), 16'h0000);
    check("rst_instr", instr, 16'h0800);
    check("rst_pcnext", PC_Next, 16'h0002);
    check("rst_err",   16'(err), 16'h0000);
    rst = 1'b0;
    #1;
    check("post_rst_rd",   16'(imem_rd), 16'h0001);
    check("post_rst_addr", imem_addr, 16'h0000);

    // Zero-wait streaming.
    tick();
    check("zw_instr0",  instr, 16'h4001);
    check("zw_pcnext0", PC_Next, 16'h0002);
    check("zw_valid0",  16'(instr_valid), 16'h0001);
    tick();
    check("zw_instr1",  instr, 16'h4802);
    check("zw_pcnext1", PC_Next, 16'h0004);

    // Stall holds the output and PC; no request issued.
    Stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stall_rd", 16'(imem_rd), 16'h0000);
      tick();
      check("stall_instr",  instr, 16'h4802);
      check("stall_pcnext", PC_Next, 16'h0004);
      check("stall_addr",   imem_addr, 16'h0004);
    end
    Stall = 1'b0;
    #1;
    check("unstall_rd", 16'(imem_rd), 16'h0001);
    tick();
    check("unstall_instr",  instr, 16'hA504);
    check("unstall_pcnext", PC_Next, 16'h0006);

    // Memory completing three cycles late.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) done_manual = 1'b1;
      #1;
      check("wait_addr",  imem_addr, 16'h0000);
      check("wait_rd",    16'(imem_rd), 16'h0001);
      check("wait_valid", 16'(instr_valid), 16'h0000);
      tick();
    end
    done_manual = 1'b0;
    check("wait_done_valid", 16'(instr_valid), 16'h0001);
    check("wait_done_instr", instr, 16'h4001);
    tick();
    check("wait_next_valid", 16'(instr_valid), 16'h0000);
    check("wait_next_addr",  imem_addr, 16'h0002);

    // Redirect while a read is outstanding.
    PC_Sel = 1'b1; PC_In = 16'h0100;
    tick();
    PC_Sel = 1'b0; PC_In = '0;
    check("redir_hold_addr", imem_addr, 16'h0002);
    done_manual = 1'b1;
    tick();
    done_manual = 1'b0;
    check("redir_discard_valid", 16'(instr_valid), 16'h0000);
    check("redir_discard_instr", instr, 16'h0800);
    check("redir_new_addr",      imem_addr, 16'h0100);
    done_manual = 1'b1;
    tick();
    done_manual = 1'b0;
    check("redir_valid",  16'(instr_valid), 16'h0001);
    check("redir_pcnext", PC_Next, 16'h0102);
    check("redir_instr",  instr, 16'hA400);

    // Redirect to the top of memory and PC wrap.
    do_reset(1'b1);
    PC_Sel = 1'b1; PC_In = 16'hFFFE;
    tick();
    PC_Sel = 1'b0;
    check("wrap_valid", 16'(instr_valid), 16'h0000);
    check("wrap_addr",  imem_addr, 16'hFFFE);
    tick();
    check("wrap_instr",  instr, 16'h5AFE);
    check("wrap_pcnext", PC_Next, 16'h0000);
    check("wrap_next_addr", imem_addr, 16'h0000);

    // Halt, with a misaligned redirect in the same cycle that must lose.
    do_reset(1'b1);
    tick();
    nHaltSig = 1'b0; PC_Sel = 1'b1; PC_In = 16'h0101;
    tick();
    nHaltSig = 1'b1; PC_Sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin PC_Sel = 1'b1; PC_In = 16'h0200; end
      #1;
      check("halt_rd",    16'(imem_rd), 16'h0000);
      check("halt_instr", instr, 16'h0800);
      check("halt_valid", 16'(instr_valid), 16'h0000);
      check("halt_addr",  imem_addr, 16'h0002);
      check("halt_err",   16'(err), 16'h0000);
      tick();
      PC_Sel = 1'b0;
    end

    // Misaligned redirect: sticky error and halt.
    do_reset(1'b1);
    tick();
    PC_Sel = 1'b1; PC_In = 16'h0101;
    tick();
    PC_Sel = 1'b0; PC_In = '0;
    for (int i = 0; i < 3; i++) begin
      check("odd_err",   16'(err), 16'h0001);
      check("odd_rd",    16'(imem_rd), 16'h0000);
      check("odd_valid", 16'(instr_valid), 16'h0000);
      check("odd_instr", instr, 16'h0800);
      tick();
    end
    do_reset(1'b1);
    check("odd_err_cleared", 16'(err), 16'h0000);
    check("odd_rd_resumed",  16'(imem_rd), 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, 16'h0800, instruction word driven when no valid instruction is held.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 PC_In  input  16  redirect target (branch/jump) from execute.
REQ-006 PC_Sel  input  1  1 = redirect: next fetch uses PC_In.
REQ-007 nHaltSig  input  1  0 = halt decoded for the instruction currently held at the output.
REQ-008 Stall  input  1  1 = decode cannot accept the held instruction this cycle.
REQ-009 imem_rd  output  1  instruction memory read request.
REQ-010 imem_addr  output  16  instruction memory word address (byte address, bit 0 = 0).
REQ-011 imem_data  input  16  instruction memory read data, valid when imem_done = 1.
REQ-012 imem_done  input  1  read complete; may assert in the same cycle as imem_rd (zero wait) or later.
REQ-013 instr  output  16  instruction presented to decode.
REQ-014 instr_valid  output  1  instr/PC_Next are valid.
REQ-015 PC_Next  output  16  PC of held instruction + 2.
REQ-016 err  output  1  sticky misaligned-fetch error.

Function
REQ-017 The block SHALL implement states FETCH, WAIT, HALTED plus a one-entry output register (instr, PC_Next, instr_valid).
REQ-018 In FETCH and WAIT, imem_rd SHALL be 1 and imem_addr SHALL equal PC, held stable until imem_done.
REQ-019 A request SHALL be issued only when the output register is empty or is consumed this cycle (instr_valid=1 and Stall=0); otherwise imem_rd=0 and PC holds.
REQ-020 FETCH->WAIT when imem_rd=1 and imem_done=0; WAIT->FETCH on imem_done=1; FETCH stays FETCH on imem_done=1.
REQ-021 On imem_done=1, with no pending redirect: instr<=imem_data, PC_Next<=PC+2, instr_valid<=1, PC<=PC+2 (16-bit wrap, 16'hFFFE+2 = 16'h0000).
REQ-022 PC_Sel=1 SHALL take priority over sequential update: PC<=PC_In, instr_valid<=0 (held instruction squashed) next cycle.
REQ-023 PC_Sel=1 while a read is outstanding SHALL set a pending-redirect flag; the returned word SHALL be discarded (instr_valid stays 0) and the next request SHALL use PC_In.
REQ-024 Held instruction with Stall=1 SHALL keep instr, PC_Next, instr_valid unchanged.
REQ-025 When instr_valid=1 and nHaltSig=0, the block SHALL enter HALTED next cycle: imem_rd=0, PC frozen, instr=NOP_INSTR, instr_valid=0, until rst.
REQ-026 PC_Sel=1 with PC_In[0]=1 SHALL set err=1 (sticky) and enter HALTED; no request issued to the odd address.
REQ-027 PC_Sel and nHaltSig=0 in the same cycle: halt wins.
REQ-028 instr SHALL equal NOP_INSTR whenever instr_valid=0.

Reset
REQ-029 On rst=1 at a clock edge: PC=RESET_PC, state=FETCH, instr_valid=0, instr=NOP_INSTR, PC_Next=RESET_PC+2, err=0, pending-redirect=0.
REQ-030 rst during WAIT SHALL abandon the outstanding read; a late imem_done after reset SHALL be treated as completion of the new RESET_PC request only if imem_rd was asserted for it.
REQ-031 imem_rd SHALL be 0 during the reset cycle and 1 in the first cycle after reset.

Structure
REQ-032 Shared package SHALL hold the state encoding, NOP_INSTR, RESET_PC default and the PC increment constant (2).
REQ-033 PC register SHALL be one sub-module, pc_reg (16-bit, load-enable, synchronous reset to RESET_PC).

Verification
REQ-034 Reset then imem_done tied 1, mem[0]=16'h4001, mem[2]=16'h4802, Stall=0 -> instr 4001 then 4802 on consecutive cycles, PC_Next 0002 then 0004.
REQ-035 imem_done delayed 3 cycles -> imem_addr held at 0000 for 4 cycles, instr_valid=0 until done, then 1 for one word.
REQ-036 Stall=1 for 2 cycles with valid instr -> instr, PC_Next unchanged, imem_rd=0, PC unchanged; resumes on Stall=0.
REQ-037 PC_Sel=1, PC_In=16'h0100 during WAIT -> returned word discarded, next imem_addr=0100, first valid PC_Next=0102.
REQ-038 nHaltSig=0 with valid instr -> imem_rd=0 forever, instr=0800, instr_valid=0 until rst; PC_Sel=1, PC_In=16'h0101 -> err=1 sticky, HALTED.
